// File: rtl/leve1_axir_arb.sv
// Two-to-one round-robin read arbiter: instruction fetch (I) and data load (D) share a single-beat
// AXI-style read port (M); responses return in order and are steered by an ID FIFO.
module leve1_axir_arb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic                         I_ARVALID,
  output logic                         I_ARREADY,
  input  logic [XLEN-1:0]              I_ARADDR,
  output logic                         I_RVALID,
  input  logic                         I_RREADY,
  output logic [XLEN-1:0]              I_RDATA,
  output logic [1:0]                   I_RRESP,
  input  logic                         D_ARVALID,
  output logic                         D_ARREADY,
  input  logic [XLEN-1:0]              D_ARADDR,
  output logic                         D_RVALID,
  input  logic                         D_RREADY,
  output logic [XLEN-1:0]              D_RDATA,
  output logic [1:0]                   D_RRESP,
  output logic                         M_ARVALID,
  input  logic                         M_ARREADY,
  output logic [XLEN-1:0]              M_ARADDR,
  input  logic                         M_RVALID,
  output logic                         M_RREADY,
  input  logic [XLEN-1:0]              M_RDATA,
  input  logic [1:0]                   M_RRESP,
  output logic [$clog2(DEPTH+1)-1:0]   OCNT
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e          state_q;
  logic            prio_i_q;     // 1: I wins a tie, 0: D wins a tie
  logic            m_arvalid_q;
  logic [XLEN-1:0] m_araddr_q;

  logic            fifo_q [DEPTH];  // 1: entry belongs to I
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   ocnt_q;

  logic can_grant, grant_i, grant_d, grant, empty, head_i, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    // Reset gating keeps ARREADY low while RSTn is held, regardless of ARVALID.
    can_grant = RSTn && (state_q == StIdle) && (ocnt_q < CW'(DEPTH));
    grant_i   = can_grant && I_ARVALID && (!D_ARVALID || prio_i_q);
    grant_d   = can_grant && D_ARVALID && (!I_ARVALID || !prio_i_q);
    grant     = grant_i || grant_d;
    empty     = (ocnt_q == '0);
    head_i    = fifo_q[rptr_q];
    M_RREADY  = !empty && (head_i ? I_RREADY : D_RREADY);
    I_RVALID  = !empty && head_i && M_RVALID;
    D_RVALID  = !empty && !head_i && M_RVALID;
    pop       = M_RVALID && M_RREADY;
  end

  assign I_ARREADY = grant_i;
  assign D_ARREADY = grant_d;
  assign I_RDATA   = M_RDATA;
  assign I_RRESP   = M_RRESP;
  assign D_RDATA   = M_RDATA;
  assign D_RRESP   = M_RRESP;
  assign M_ARVALID = m_arvalid_q;
  assign M_ARADDR  = m_araddr_q;
  assign OCNT      = ocnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= StIdle;
      prio_i_q    <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant) begin
            m_araddr_q  <= grant_i ? I_ARADDR : D_ARADDR;
            m_arvalid_q <= 1'b1;
            prio_i_q    <= grant_d;  // priority goes to whoever was not granted
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (M_ARREADY) begin
            m_arvalid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      ocnt_q <= '0;
    end else begin
      if (grant) begin
        fifo_q[wptr_q] <= grant_i;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (grant && !pop)      ocnt_q <= ocnt_q + CW'(1);
      else if (!grant && pop) ocnt_q <= ocnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_leve1_axir_arb.sv
// Self-checking bench for leve1_axir_arb: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_leve1_axir_arb;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic            I_ARVALID, I_ARREADY, I_RVALID, I_RREADY;
  logic [XLEN-1:0] I_ARADDR, I_RDATA;
  logic [1:0]      I_RRESP;
  logic            D_ARVALID, D_ARREADY, D_RVALID, D_RREADY;
  logic [XLEN-1:0] D_ARADDR, D_RDATA;
  logic [1:0]      D_RRESP;
  logic            M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [XLEN-1:0] M_ARADDR, M_RDATA;
  logic [1:0]      M_RRESP;
  logic [$clog2(DEPTH+1)-1:0] OCNT;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {bit id; logic [XLEN-1:0] addr;} txn_t;  // id 1 = I

  always #5 CLK = ~CLK;

  leve1_axir_arb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .I_ARVALID(I_ARVALID), .I_ARREADY(I_ARREADY), .I_ARADDR(I_ARADDR),
    .I_RVALID(I_RVALID), .I_RREADY(I_RREADY), .I_RDATA(I_RDATA), .I_RRESP(I_RRESP),
    .D_ARVALID(D_ARVALID), .D_ARREADY(D_ARREADY), .D_ARADDR(D_ARADDR),
    .D_RVALID(D_RVALID), .D_RREADY(D_RREADY), .D_RDATA(D_RDATA), .D_RRESP(D_RRESP),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .OCNT(OCNT)
  );

  function automatic logic [XLEN-1:0] mdata(input logic [XLEN-1:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic do_reset();
    RSTn = 1'b0;
    I_ARVALID = 0; I_ARADDR = 0; I_RREADY = 0;
    D_ARVALID = 0; D_ARADDR = 0; D_RREADY = 0;
    M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    I_ARVALID = 1; D_ARVALID = 1; I_ARADDR = 32'h10; D_ARADDR = 32'h20;
    I_RREADY = 1; D_RREADY = 1; M_ARREADY = 1; M_RVALID = 1; M_RDATA = 32'h1234; M_RRESP = 0;
    @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (M_ARVALID !== 1'b0) begin n_err++;
      $display("FAIL rst_m_arvalid got=%0h exp=0", M_ARVALID); end
    n_cmp++; if (M_ARADDR !== '0) begin n_err++;
      $display("FAIL rst_m_araddr got=%0h exp=0", M_ARADDR); end
    n_cmp++; if (OCNT !== 2'd0) begin n_err++; $display("FAIL rst_ocnt got=%0d exp=0", OCNT); end
    n_cmp++; if ({I_ARREADY, D_ARREADY} !== 2'b00) begin n_err++;
      $display("FAIL rst_arready got=%b exp=00", {I_ARREADY, D_ARREADY}); end
    n_cmp++; if ({I_RVALID, D_RVALID, M_RREADY} !== 3'b000) begin n_err++;
      $display("FAIL rst_rvalid got=%b exp=000", {I_RVALID, D_RVALID, M_RREADY}); end
  endtask

  task automatic test_single_instr();
    do_reset();
    I_ARVALID = 1; I_ARADDR = 32'h0000_0100; M_ARREADY = 1; I_RREADY = 1; D_RREADY = 1;
    @(negedge CLK);
    n_cmp++; if ({I_ARREADY, D_ARREADY} !== 2'b10) begin n_err++;
      $display("FAIL single_arready got=%b exp=10", {I_ARREADY, D_ARREADY}); end
    n_cmp++; if (OCNT !== 2'd0) begin n_err++; $display("FAIL single_ocnt0 got=%0d exp=0", OCNT); end
    @(posedge CLK); #1 I_ARVALID = 0;
    @(negedge CLK);
    n_cmp++; if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h100) begin n_err++;
      $display("FAIL single_m_ar got=%0h/%0h exp=1/100", M_ARVALID, M_ARADDR); end
    n_cmp++; if (OCNT !== 2'd1) begin n_err++; $display("FAIL single_ocnt1 got=%0d exp=1", OCNT); end
    @(posedge CLK); #1 M_ARREADY = 0;
    @(negedge CLK);
    n_cmp++; if (M_ARVALID !== 1'b0) begin n_err++;
      $display("FAIL single_m_ardrop got=%0h exp=0", M_ARVALID); end
    @(posedge CLK); #1 M_RVALID = 1; M_RDATA = 32'h0000_0013; M_RRESP = 2'b00;
    @(negedge CLK);
    n_cmp++; if (I_RVALID !== 1'b1 || I_RDATA !== 32'h13) begin n_err++;
      $display("FAIL single_i_r got=%0h/%0h exp=1/13", I_RVALID, I_RDATA); end
    n_cmp++; if (D_RVALID !== 1'b0 || M_RREADY !== 1'b1) begin n_err++;
      $display("FAIL single_route got=%0h/%0h exp=0/1", D_RVALID, M_RREADY); end
    @(posedge CLK); #1 M_RVALID = 0;
    @(negedge CLK);
    n_cmp++; if (OCNT !== 2'd0) begin n_err++; $display("FAIL single_ocnt2 got=%0d exp=0", OCNT); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    I_ARVALID = 1; I_ARADDR = 32'h200; D_ARVALID = 1; D_ARADDR = 32'h8000;
    M_ARREADY = 1; I_RREADY = 1; D_RREADY = 1;
    @(negedge CLK);
    n_cmp++; if ({I_ARREADY, D_ARREADY} !== 2'b01) begin n_err++;
      $display("FAIL simul_first got=%b exp=01", {I_ARREADY, D_ARREADY}); end
    @(posedge CLK); #1 D_ARVALID = 0;
    @(negedge CLK);
    n_cmp++; if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h8000 || I_ARREADY !== 1'b0) begin
      n_err++; $display("FAIL simul_m_d got=%0h/%0h/%0h exp=1/8000/0",
                        M_ARVALID, M_ARADDR, I_ARREADY); end
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++; if (I_ARREADY !== 1'b1 || M_ARVALID !== 1'b0) begin n_err++;
      $display("FAIL simul_second got=%0h/%0h exp=1/0", I_ARREADY, M_ARVALID); end
    @(posedge CLK); #1 I_ARVALID = 0;
    @(negedge CLK);
    n_cmp++; if (M_ARADDR !== 32'h200) begin n_err++;
      $display("FAIL simul_m_i got=%0h exp=200", M_ARADDR); end
    @(posedge CLK); #1 M_ARREADY = 0; M_RVALID = 1; M_RDATA = 32'hAAAA_0001; M_RRESP = 2'b10;
    @(negedge CLK);
    n_cmp++; if ({D_RVALID, I_RVALID} !== 2'b10 || D_RDATA !== 32'hAAAA_0001 || D_RRESP !== 2'b10)
    begin n_err++; $display("FAIL simul_resp_a got=%b/%0h/%0h exp=10/aaaa0001/2",
                            {D_RVALID, I_RVALID}, D_RDATA, D_RRESP); end
    @(posedge CLK); #1 M_RDATA = 32'hBBBB_0002; M_RRESP = 2'b00;
    @(negedge CLK);
    n_cmp++; if ({D_RVALID, I_RVALID} !== 2'b01 || I_RDATA !== 32'hBBBB_0002) begin n_err++;
      $display("FAIL simul_resp_b got=%b/%0h exp=01/bbbb0002", {D_RVALID, I_RVALID}, I_RDATA); end
    @(posedge CLK); #1 M_RVALID = 0;
    @(negedge CLK);
    n_cmp++; if (OCNT !== 2'd0) begin n_err++; $display("FAIL simul_ocnt got=%0d exp=0", OCNT); end
  endtask

  task automatic test_round_robin();
    int grants = 0;
    int cnt_i = 0;
    int cnt_d = 0;
    do_reset();
    I_ARVALID = 1; I_ARADDR = 32'h1000; D_ARVALID = 1; D_ARADDR = 32'h2000;
    M_ARREADY = 1; M_RVALID = 1; M_RDATA = 32'h77; I_RREADY = 1; D_RREADY = 1;
    for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
      @(negedge CLK);
      if (I_ARREADY || D_ARREADY) begin
        // D wins first after reset, then strict alternation
        n_cmp++; if ({I_ARREADY, D_ARREADY} !== ((grants % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", grants, {I_ARREADY, D_ARREADY},
                            (grants % 2 == 0) ? 2'b01 : 2'b10); end
        if (I_ARREADY) cnt_i++;
        if (D_ARREADY) cnt_d++;
        grants++;
      end
      @(posedge CLK); #1;
    end
    n_cmp++; if (cnt_i != 4 || cnt_d != 4) begin n_err++;
      $display("FAIL rr_counts got=i%0d/d%0d exp=i4/d4", cnt_i, cnt_d); end
  endtask

  task automatic test_full();
    do_reset();
    I_ARVALID = 1; I_ARADDR = 32'h300; D_ARVALID = 1; D_ARADDR = 32'h400;
    M_ARREADY = 1; I_RREADY = 1; D_RREADY = 1;
    repeat (4) @(posedge CLK);
    #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      n_cmp++; if (OCNT !== 2'd2 || {I_ARREADY, D_ARREADY} !== 2'b00) begin n_err++;
        $display("FAIL full_hold%0d got=%0d/%b exp=2/00", k, OCNT, {I_ARREADY, D_ARREADY}); end
      @(posedge CLK); #1;
    end
    M_RVALID = 1; M_RDATA = 32'h44;
    @(negedge CLK);
    n_cmp++; if (D_RVALID !== 1'b1 || M_RREADY !== 1'b1 || {I_ARREADY, D_ARREADY} !== 2'b00) begin
      n_err++; $display("FAIL full_pop got=%0h/%0h/%b exp=1/1/00",
                        D_RVALID, M_RREADY, {I_ARREADY, D_ARREADY}); end
    @(posedge CLK); #1 M_RVALID = 0;
    @(negedge CLK);
    n_cmp++; if (OCNT !== 2'd1 || {I_ARREADY, D_ARREADY} !== 2'b01) begin n_err++;
      $display("FAIL full_regrant got=%0d/%b exp=1/01", OCNT, {I_ARREADY, D_ARREADY}); end
  endtask

  task automatic test_stall();
    do_reset();
    D_ARVALID = 1; D_ARADDR = 32'hDEAD_BEE0; M_ARREADY = 0; D_RREADY = 0;
    @(negedge CLK);
    n_cmp++; if (D_ARREADY !== 1'b1) begin n_err++;
      $display("FAIL stall_grant got=%0h exp=1", D_ARREADY); end
    @(posedge CLK); #1 D_ARVALID = 0; D_ARADDR = 32'h1111_2222;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      n_cmp++; if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'hDEAD_BEE0) begin n_err++;
        $display("FAIL stall_ar%0d got=%0h/%0h exp=1/deadbee0", k, M_ARVALID, M_ARADDR); end
      @(posedge CLK); #1;
    end
    M_ARREADY = 1;
    @(posedge CLK); #1 M_ARREADY = 0; M_RVALID = 1; M_RDATA = 32'hCAFE; M_RRESP = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      n_cmp++; if (M_RREADY !== 1'b0 || D_RVALID !== 1'b1 || OCNT !== 2'd1) begin n_err++;
        $display("FAIL stall_r%0d got=%0h/%0h/%0d exp=0/1/1", k, M_RREADY, D_RVALID, OCNT); end
      @(posedge CLK); #1;
    end
    D_RREADY = 1;
    @(negedge CLK);
    n_cmp++; if (M_RREADY !== 1'b1 || D_RRESP !== 2'b11) begin n_err++;
      $display("FAIL stall_accept got=%0h/%0h exp=1/3", M_RREADY, D_RRESP); end
    @(posedge CLK); #1;
    @(negedge CLK);
    n_cmp++; if (OCNT !== 2'd0 || M_RREADY !== 1'b0 || D_RVALID !== 1'b0) begin n_err++;
      $display("FAIL stall_single_pop got=%0d/%0h/%0h exp=0/0/0", OCNT, M_RREADY, D_RVALID); end
    @(posedge CLK); #1 M_RVALID = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    D_ARVALID = 1; D_ARADDR = 32'h500; M_ARREADY = 0;
    @(posedge CLK); #1 D_ARVALID = 0;
    @(negedge CLK);
    n_cmp++; if (M_ARVALID !== 1'b1 || OCNT !== 2'd1) begin n_err++;
      $display("FAIL arst_pre got=%0h/%0d exp=1/1", M_ARVALID, OCNT); end
    #1 RSTn = 1'b0;
    #1;
    n_cmp++; if (M_ARVALID !== 1'b0 || OCNT !== 2'd0 || M_ARADDR !== '0) begin n_err++;
      $display("FAIL arst_now got=%0h/%0d/%0h exp=0/0/0", M_ARVALID, OCNT, M_ARADDR); end
    @(posedge CLK); #1 RSTn = 1'b1;
    I_ARVALID = 1; I_ARADDR = 32'h600; D_ARVALID = 1; D_ARADDR = 32'h700;
    @(negedge CLK);
    n_cmp++; if ({I_ARREADY, D_ARREADY} !== 2'b01) begin n_err++;
      $display("FAIL arst_prio got=%b exp=01", {I_ARREADY, D_ARREADY}); end
  endtask

  task automatic test_random();
    txn_t            outq[$];
    logic [XLEN-1:0] memq[$];
    bit              prio_i = 0;
    bit              iss_pending = 0;
    logic [XLEN-1:0] iss_addr = '0;
    bit              gi, gd, ar_fire, r_fire, allow, has, head, exp_mrr;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!I_ARVALID && $urandom_range(0, 2) == 0) begin
        I_ARVALID = 1; I_ARADDR = $urandom & 32'hFFFF_FFFC;
      end
      if (!D_ARVALID && $urandom_range(0, 2) == 0) begin
        D_ARVALID = 1; D_ARADDR = $urandom & 32'hFFFF_FFFC;
      end
      M_ARREADY = 1'($urandom_range(0, 1));
      if (!M_RVALID && memq.size() > 0 && $urandom_range(0, 1) == 1) begin
        M_RVALID = 1; M_RDATA = mdata(memq[0]); M_RRESP = memq[0][3:2];
      end
      I_RREADY = 1'($urandom_range(0, 1));
      D_RREADY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      allow   = !iss_pending && outq.size() < DEPTH;
      gi      = allow && I_ARVALID && (!D_ARVALID || prio_i);
      gd      = allow && D_ARVALID && (!I_ARVALID || !prio_i);
      has     = outq.size() > 0;
      head    = has ? outq[0].id : 1'b0;
      exp_mrr = has && (head ? I_RREADY : D_RREADY);
      n_cmp++; if ({I_ARREADY, D_ARREADY} !== {gi, gd}) begin n_err++;
        $display("FAIL rnd_arready cyc=%0d got=%b exp=%b", cyc, {I_ARREADY, D_ARREADY}, {gi, gd}); end
      n_cmp++; if (M_ARVALID !== iss_pending || (iss_pending && M_ARADDR !== iss_addr)) begin
        n_err++; $display("FAIL rnd_m_ar cyc=%0d got=%0h/%0h exp=%0h/%0h",
                          cyc, M_ARVALID, M_ARADDR, iss_pending, iss_addr); end
      n_cmp++; if (OCNT !== 2'(outq.size())) begin n_err++;
        $display("FAIL rnd_ocnt cyc=%0d got=%0d exp=%0d", cyc, OCNT, outq.size()); end
      n_cmp++; if ({I_RVALID, D_RVALID, M_RREADY} !==
                   {has && head && M_RVALID, has && !head && M_RVALID, exp_mrr}) begin n_err++;
        $display("FAIL rnd_r_ctl cyc=%0d got=%b exp=%b", cyc, {I_RVALID, D_RVALID, M_RREADY},
                 {has && head && M_RVALID, has && !head && M_RVALID, exp_mrr}); end
      if (has && M_RVALID) begin
        n_cmp++;
        if ((head ? I_RDATA : D_RDATA) !== mdata(outq[0].addr) ||
            (head ? I_RRESP : D_RRESP) !== outq[0].addr[3:2]) begin n_err++;
          $display("FAIL rnd_r_data cyc=%0d got=%0h exp=%0h", cyc,
                   head ? I_RDATA : D_RDATA, mdata(outq[0].addr)); end
      end
      ar_fire = iss_pending && M_ARREADY;
      r_fire  = M_RVALID && exp_mrr;
      @(posedge CLK); #1;
      if (r_fire) begin
        void'(outq.pop_front());
        void'(memq.pop_front());
        M_RVALID = 0;
      end
      if (ar_fire) begin
        memq.push_back(iss_addr);
        iss_pending = 0;
      end
      if (gi || gd) begin
        txn_t t;
        t.id = gi;
        t.addr = gi ? I_ARADDR : D_ARADDR;
        outq.push_back(t);
        iss_pending = 1;
        iss_addr = t.addr;
        prio_i = gd;
        if (gi) I_ARVALID = 0;
        else D_ARVALID = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_instr();
    test_simultaneous();
    test_round_robin();
    test_full();
    test_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
